// File: rtl/tl_inflight_monitor.sv
// Observe-only TileLink-UL/UH in-flight checker for one A/D channel pair.
// Define TL_INFLIGHT_MON_TIMEOUT_EN to compile in the response watchdog (err_flags[6]).
module tl_inflight_monitor #(
   parameter int SOURCE_W    = 2,
   parameter int ADDR_W      = 32,
   parameter int BEAT_BYTES  = 4,
   parameter int TIMEOUT_CYC = 256
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  a_valid,
   input  logic                  a_ready,
   input  logic [2:0]            a_opcode,
   input  logic [3:0]            a_size,
   input  logic [SOURCE_W-1:0]   a_source,
   input  logic [ADDR_W-1:0]     a_address,
   input  logic [BEAT_BYTES-1:0] a_mask,
   input  logic                  d_valid,
   input  logic                  d_ready,
   input  logic [2:0]            d_opcode,
   input  logic [3:0]            d_size,
   input  logic [SOURCE_W-1:0]   d_source,
   input  logic                  clear_err,
   output logic [6:0]            err_flags,
   output logic                  err_pulse,
   output logic [SOURCE_W:0]     inflight_cnt
);

   localparam int LG_BEAT = $clog2(BEAT_BYTES);
   localparam int NSRC    = 1 << SOURCE_W;
   localparam int CNT_W   = 16;

   localparam logic [2:0] OP_PUT_FULL    = 3'd0;
   localparam logic [2:0] OP_PUT_PARTIAL = 3'd1;
   localparam logic [2:0] OP_GET         = 3'd4;
   localparam logic [2:0] OP_ACK_DATA    = 3'd1;

   localparam int ERR_A_DUP     = 0;
   localparam int ERR_D_ORPHAN  = 1;
   localparam int ERR_D_OPCODE  = 2;
   localparam int ERR_A_STABLE  = 3;
   localparam int ERR_A_ILLEGAL = 4;
   localparam int ERR_D_SIZE    = 5;
   localparam int ERR_TIMEOUT   = 6;

   typedef struct packed {
      logic       exp_data;
      logic [3:0] size;
   } entry_t;

   function automatic logic [CNT_W-1:0] beats_of(input logic [3:0] size);
      if (int'(size) > LG_BEAT) return CNT_W'(1) << (int'(size) - LG_BEAT);
      return CNT_W'(1);
   endfunction

   // Byte lanes a sub-beat Get must enable: 2^size contiguous lanes at the address offset.
   function automatic logic [BEAT_BYTES-1:0] get_mask(input logic [3:0] size,
                                                      input logic [ADDR_W-1:0] addr);
      logic [BEAT_BYTES-1:0] ones;
      int lanes;
      int offs;
      lanes = 1 << size;
      offs  = int'(addr & ADDR_W'(BEAT_BYTES - 1));
      ones  = '0;
      for (int i = 0; i < BEAT_BYTES; i++) begin
         if (i < lanes) ones[i] = 1'b1;
      end
      return ones << offs;
   endfunction

   function automatic logic [SOURCE_W:0] popcount(input logic [NSRC-1:0] v);
      logic [SOURCE_W:0] c;
      c = '0;
      for (int i = 0; i < NSRC; i++) c = c + (SOURCE_W+1)'(v[i]);
      return c;
   endfunction

   logic              a_fire, d_fire;
   logic              a_first, d_first, d_orphan, d_clear;
   logic [CNT_W-1:0]  a_cnt, d_cnt, a_cnt_next, d_cnt_next;
   logic [CNT_W-1:0]  a_beats, d_beats;
   logic [NSRC-1:0]   pend, pend_next;
   entry_t            tbl [NSRC];
   logic              a_bad_op, a_misaligned, a_bad_mask;
   logic              det_timeout;
   logic [6:0]        det;

   logic              stall_q;
   logic [2:0]        op_q;
   logic [3:0]        size_q;
   logic [SOURCE_W-1:0] src_q;
   logic [ADDR_W-1:0] addr_q;

   assign a_fire   = a_valid & a_ready;
   assign d_fire   = d_valid & d_ready;
   assign a_first  = a_fire && (a_cnt == '0);
   assign d_first  = d_fire && (d_cnt == '0);
   assign d_orphan = d_first && !pend[d_source];

   assign a_beats = (a_opcode == OP_PUT_FULL || a_opcode == OP_PUT_PARTIAL) ?
                    beats_of(a_size) : CNT_W'(1);
   assign d_beats = (d_opcode == OP_ACK_DATA) ? beats_of(d_size) : CNT_W'(1);

   // An orphan response is treated as a lone beat and never retires anything.
   assign d_clear = d_fire && !d_orphan &&
                    (d_first ? (d_beats == CNT_W'(1)) : (d_cnt == CNT_W'(1)));

   assign a_bad_op     = !(a_opcode inside {OP_PUT_FULL, OP_PUT_PARTIAL, OP_GET});
   assign a_misaligned = (a_address & ~({ADDR_W{1'b1}} << a_size)) != '0;
   assign a_bad_mask   = (a_opcode == OP_GET) && (int'(a_size) < LG_BEAT) &&
                         (a_mask != get_mask(a_size, a_address));

   // NOTE: every variable assigned in a combinational block gets a default first,
   // so no path can leave it unassigned and infer a latch.
   always_comb begin
      a_cnt_next = a_cnt;
      d_cnt_next = d_cnt;
      if (a_fire) a_cnt_next = a_first ? a_beats - CNT_W'(1) : a_cnt - CNT_W'(1);
      if (d_fire) begin
         if (!d_first)     d_cnt_next = d_cnt - CNT_W'(1);
         else if (d_orphan) d_cnt_next = '0;
         else              d_cnt_next = d_beats - CNT_W'(1);
      end
   end

   // A new request on a source wins over a same-cycle retirement of that source.
   always_comb begin
      pend_next = pend;
      if (d_clear) pend_next[d_source] = 1'b0;
      if (a_first) pend_next[a_source] = 1'b1;
   end

   always_comb begin
      det = '0;
      det[ERR_A_DUP]     = a_first && pend[a_source] &&
                           !(d_clear && (d_source == a_source));
      det[ERR_D_ORPHAN]  = d_orphan;
      det[ERR_D_OPCODE]  = d_first && !d_orphan &&
                           (d_opcode != {2'b00, tbl[d_source].exp_data});
      det[ERR_D_SIZE]    = d_first && !d_orphan &&
                           (d_opcode == {2'b00, tbl[d_source].exp_data}) &&
                           (d_size != tbl[d_source].size);
      det[ERR_A_STABLE]  = stall_q && (!a_valid || a_opcode != op_q || a_size != size_q ||
                                       a_source != src_q || a_address != addr_q);
      det[ERR_A_ILLEGAL] = a_first && (a_bad_op || a_misaligned || a_bad_mask);
      det[ERR_TIMEOUT]   = det_timeout;
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of block ordering.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         a_cnt        <= '0;
         d_cnt        <= '0;
         pend         <= '0;
         inflight_cnt <= '0;
         // NOTE: the source table is small and must read back as empty after
         // reset, so it is reset explicitly rather than left as uninitialised RAM.
         for (int i = 0; i < NSRC; i++) tbl[i] <= '0;
      end else begin
         a_cnt        <= a_cnt_next;
         d_cnt        <= d_cnt_next;
         pend         <= pend_next;
         inflight_cnt <= popcount(pend_next);
         if (a_first) tbl[a_source] <= '{exp_data: (a_opcode == OP_GET), size: a_size};
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         stall_q <= 1'b0;
         op_q    <= '0;
         size_q  <= '0;
         src_q   <= '0;
         addr_q  <= '0;
      end else begin
         stall_q <= a_valid & ~a_ready;
         op_q    <= a_opcode;
         size_q  <= a_size;
         src_q   <= a_source;
         addr_q  <= a_address;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         err_flags <= '0;
         err_pulse <= 1'b0;
      end else begin
         err_pulse <= |det;
         err_flags <= clear_err ? det : (err_flags | det);
      end
   end

`ifdef TL_INFLIGHT_MON_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

   logic [WD_W-1:0] wd_q;

   // Fires once on the cycle the count would reach the limit, then parks there.
   assign det_timeout = (inflight_cnt != '0) && !d_fire &&
                        (wd_q == WD_W'(TIMEOUT_CYC - 1));

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wd_q <= '0;
      end else if (inflight_cnt == '0 || d_fire) begin
         wd_q <= '0;
      end else if (wd_q != WD_W'(TIMEOUT_CYC)) begin
         wd_q <= wd_q + WD_W'(1);
      end
   end
`else
   logic unused_timeout_cfg;

   assign det_timeout        = 1'b0;
   assign unused_timeout_cfg = (TIMEOUT_CYC > 0);
`endif

endmodule
